// File: rtl/popcount_stream.sv
// Two-stage pipelined population counter with valid/ready handshake,
// parity, threshold flag and a saturating running accumulation of counts.
module popcount_stream #(
  parameter int WIDTH  = 16,
  parameter int ACC_W  = 16,
  parameter int THRESH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_parity,
  output logic             out_ge,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  localparam int unsigned LW = (WIDTH + 1) / 2;
  localparam int unsigned UW = WIDTH / 2;

  logic             stall;
  logic [CW-1:0]    lo_cnt, hi_cnt, sum;
  logic [ACC_W:0]   acc_wide;
  logic [ACC_W-1:0] acc_nxt;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_clr_q, s1_clr_d;
  logic [CW-1:0]    s1_lo_q, s1_lo_d;
  logic [CW-1:0]    s1_hi_q, s1_hi_d;

  logic             valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic             parity_q, parity_d;
  logic             ge_q, ge_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  always_comb begin
    lo_cnt = '0;
    hi_cnt = '0;
    for (int unsigned i = 0; i < LW; i++) lo_cnt = lo_cnt + CW'(in_data[i]);
    for (int unsigned i = 0; i < UW; i++) hi_cnt = hi_cnt + CW'(in_data[LW + i]);
  end

  always_comb begin
    stall    = valid_q & ~out_ready;
    sum      = s1_lo_q + s1_hi_q;
    // One extra bit on the sum exposes overflow for the saturating add.
    acc_wide = {1'b0, acc_q} + (ACC_W + 1)'(sum);
    if (s1_clr_q)            acc_nxt = ACC_W'(sum);
    else if (acc_wide[ACC_W]) acc_nxt = '1;
    else                      acc_nxt = acc_wide[ACC_W-1:0];

    s1_valid_d = s1_valid_q;
    s1_clr_d   = s1_clr_q;
    s1_lo_d    = s1_lo_q;
    s1_hi_d    = s1_hi_q;
    valid_d    = valid_q;
    count_d    = count_q;
    parity_d   = parity_q;
    ge_d       = ge_q;
    acc_d      = acc_q;
    sat_d      = sat_q;

    if (!stall) begin
      s1_valid_d = in_valid;
      s1_clr_d   = in_acc_clr;
      s1_lo_d    = lo_cnt;
      s1_hi_d    = hi_cnt;
      valid_d    = s1_valid_q;
      // Bubbles only drop out_valid; result fields and accumulator are held.
      if (s1_valid_q) begin
        count_d  = sum;
        parity_d = sum[0];
        ge_d     = (sum >= CW'(THRESH));
        acc_d    = acc_nxt;
        sat_d    = &acc_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      parity_q   <= 1'b0;
      ge_q       <= 1'b0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_clr_q   <= s1_clr_d;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      parity_q   <= parity_d;
      ge_q       <= ge_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready   = ~stall;
  assign out_valid  = valid_q;
  assign out_count  = count_q;
  assign out_parity = parity_q;
  assign out_ge     = ge_q;
  assign out_acc    = acc_q;
  assign out_sat    = sat_q;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: directed table, backpressure, random stream vs
// a queue-based reference, async reset flush, saturation and odd-width sweep.
module tb_popcount_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: WIDTH=16, ACC_W=16, THRESH=8
  logic        in_valid, in_ready, in_acc_clr, out_valid, out_ready;
  logic [15:0] in_data, out_acc;
  logic [4:0]  out_count;
  logic        out_parity, out_ge, out_sat;

  // Saturation instance: ACC_W=5
  logic        s_in_valid, s_in_ready, s_clr, s_out_valid, s_out_ready;
  logic [15:0] s_in_data;
  logic [4:0]  s_count, s_acc;
  logic        s_par, s_ge, s_sat;

  // Odd-width instance: WIDTH=7, THRESH=4
  logic        o_in_valid, o_in_ready, o_clr, o_out_valid, o_out_ready;
  logic [6:0]  o_in_data;
  logic [2:0]  o_count;
  logic [7:0]  o_acc;
  logic        o_par, o_ge, o_sat;

  popcount_stream #(.WIDTH(16), .ACC_W(16), .THRESH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_acc_clr(in_acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_parity(out_parity),
    .out_ge(out_ge), .out_acc(out_acc), .out_sat(out_sat));

  popcount_stream #(.WIDTH(16), .ACC_W(5), .THRESH(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_acc_clr(s_clr), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_count(s_count), .out_parity(s_par),
    .out_ge(s_ge), .out_acc(s_acc), .out_sat(s_sat));

  popcount_stream #(.WIDTH(7), .ACC_W(8), .THRESH(4)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_data(o_in_data), .in_acc_clr(o_clr), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .out_count(o_count), .out_parity(o_par),
    .out_ge(o_ge), .out_acc(o_acc), .out_sat(o_sat));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int cnt; bit par; bit ge; int acc; bit sat; } res_t;
  typedef struct { logic [15:0] d; logic clr; int cnt; bit par; bit ge; int acc; } vec_t;

  localparam int MAXACC = 65535;
  res_t sb[$];
  int   m_acc = 0;
  bit   use_tbl = 0;
  int   tbl_idx = 0;
  vec_t tbl[7];
  bit   prev_stall = 0;
  logic [4:0]  prev_cnt;
  logic [15:0] prev_acc;

  // One cycle on the main instance, starting at a falling edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic clr,
                     input logic ordy, output bit acc_in);
    res_t e;
    int   c;
    in_valid = v; in_data = d; in_acc_clr = clr; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (prev_stall) begin
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_count", out_count, prev_cnt);
      chk("stall_hold_acc", out_acc, prev_acc);
    end
    prev_stall = out_valid && !out_ready;
    prev_cnt = out_count;
    prev_acc = out_acc;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("count", out_count, e.cnt);
        chk("parity", out_parity, e.par);
        chk("ge", out_ge, e.ge);
        chk("acc", out_acc, e.acc);
        chk("sat", out_sat, e.sat);
      end
    end
    acc_in = v && in_ready;
    if (acc_in) begin
      c = $countones(d);
      if (clr) m_acc = c;
      else m_acc = (m_acc + c > MAXACC) ? MAXACC : m_acc + c;
      if (use_tbl) begin
        e.cnt = tbl[tbl_idx].cnt; e.par = tbl[tbl_idx].par; e.ge = tbl[tbl_idx].ge;
        e.acc = tbl[tbl_idx].acc; e.sat = 0;
        tbl_idx++;
      end else begin
        e.cnt = c; e.par = c[0]; e.ge = (c >= 8); e.acc = m_acc; e.sat = (m_acc == MAXACC);
      end
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, a);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int bi, stall_n, ge_n, c;
    logic [15:0] bp_vals[4];
    logic [15:0] sd[5];
    logic        sc[5];
    int          se_acc[6];
    bit          se_sat[6], se_v[6];

    tbl[0] = '{16'hF0F1, 1'b1, 9,  1'b1, 1'b1, 9};
    tbl[1] = '{16'h0000, 1'b1, 0,  1'b0, 1'b0, 0};
    tbl[2] = '{16'hFFFF, 1'b0, 16, 1'b0, 1'b1, 16};
    tbl[3] = '{16'h0001, 1'b0, 1,  1'b1, 1'b0, 17};
    tbl[4] = '{16'h00FF, 1'b0, 8,  1'b0, 1'b1, 25};
    tbl[5] = '{16'h007F, 1'b0, 7,  1'b1, 1'b0, 32};
    tbl[6] = '{16'h8001, 1'b1, 2,  1'b0, 1'b0, 2};

    rst_n = 1'b0;
    in_valid = 0; in_data = '0; in_acc_clr = 0; out_ready = 1;
    s_in_valid = 0; s_in_data = '0; s_clr = 0; s_out_ready = 1;
    o_in_valid = 0; o_in_data = '0; o_clr = 0; o_out_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_out_ge", out_ge, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single beat latency: nothing after the accepting edge, result after the next.
    cyc(1'b1, 16'hF0F1, 1'b1, 1'b1, a);
    #1 chk("latency_s1_only", out_valid, 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, a);
    #1 chk("latency_out_valid", out_valid, 1);
    chk("single_count", out_count, 9);
    chk("single_acc", out_acc, 9);
    drain();

    // Directed table streamed back to back.
    use_tbl = 1;
    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].d, tbl[i].clr, 1'b1, a);
      chk("tbl_accept", a, 1);
    end
    chk("tbl_no_bubble", sb.size(), 2);
    drain();
    use_tbl = 0;

    // Backpressure: first result held for 3 cycles.
    bp_vals = '{16'h1234, 16'hAAAA, 16'h0F00, 16'hFFFE};
    bi = 0; stall_n = 0;
    for (int n = 0; n < 40 && (bi < 4 || sb.size() > 0); n++) begin
      logic ordy;
      ordy = 1'b1;
      if (out_valid && stall_n < 3) begin ordy = 1'b0; stall_n++; end
      cyc(bi < 4, (bi < 4) ? bp_vals[bi] : 16'h0, bi == 0, ordy, a);
      if (a) bi++;
    end
    chk("bp_beats_sent", bi, 4);
    chk("bp_stall_cycles", stall_n, 3);
    chk("bp_all_delivered", sb.size(), 0);

    // Random stream with random backpressure.
    for (int n = 0; n < 400; n++)
      cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) < 7, a);
    drain();

    // Async reset with two beats in flight.
    cyc(1'b1, 16'h00FF, 1'b0, 1'b1, a);
    cyc(1'b1, 16'h0F0F, 1'b0, 1'b1, a);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_out_acc", out_acc, 0);
    chk("arst_out_sat", out_sat, 0);
    sb.delete(); m_acc = 0; prev_stall = 0;
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 16'h0, 1'b0, 1'b1, a);
    cyc(1'b1, 16'h0007, 1'b0, 1'b1, a);
    drain();

    // Saturation, ACC_W=5 (max 31).
    sd = '{16'hFFFF, 16'hFFFF, 16'h0003, 16'hFFFF, 16'h7FFF};
    sc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    se_v   = '{1, 1, 1, 1, 1, 0};
    se_acc = '{16, 31, 2, 16, 31, 31};
    se_sat = '{0, 1, 0, 0, 1, 1};
    for (int t = 0; t < 8; t++) begin
      s_in_valid = (t < 5);
      s_in_data  = (t < 5) ? sd[t] : 16'h0;
      s_clr      = (t < 5) ? sc[t] : 1'b0;
      #1;
      if (t >= 2) begin
        chk("sat_valid", s_out_valid, se_v[t-2]);
        chk("sat_acc", s_acc, se_acc[t-2]);
        chk("sat_flag", s_sat, se_sat[t-2]);
      end
      @(negedge clk);
    end

    // Odd width sweep of all 128 patterns.
    ge_n = 0;
    for (int t = 0; t < 130; t++) begin
      o_in_valid = (t < 128);
      o_in_data  = 7'(t);
      o_clr      = 1'b1;
      #1;
      if (t >= 2) begin
        c = $countones(7'(t - 2));
        chk("odd_valid", o_out_valid, 1);
        chk("odd_count", o_count, c);
        chk("odd_ge", o_ge, c >= 4);
        if (o_ge) ge_n++;
      end
      @(negedge clk);
    end
    chk("odd_ge_total", ge_n, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
